switch_button_reader: RTL

Bus-mapped input peripheral: debounces the 8 slide switches and 4 push buttons and returns their state to the processor on bus reads. It sits on the same BUS_ADDR/BUS_DATA/BUS_WE bus as the seven-segment writer and is the read-side counterpart to it. Button presses are also latched as sticky event flags, and the block raises a processor interrupt that is acknowledged over the bus.

---
 rtl/switch_button_pkg.sv | 31 +++
 rtl/GenericCounter.sv | 27 ++
 rtl/input_debouncer.sv | 52 +++++
 rtl/switch_button_reader.sv | 111 +++++++++++
 4 files changed

// File: rtl/switch_button_pkg.sv
// Shared constants and address decode for the switch/button bus reader.
package switch_button_pkg;

    localparam int NUM_SWITCHES = 8;
    localparam int NUM_BUTTONS  = 4;
    localparam int DEB_CNT_W    = 3;

    localparam logic [7:0] SW_OFFSET   = 8'd0;
    localparam logic [7:0] BTN_OFFSET  = 8'd1;
    localparam logic [7:0] MASK_OFFSET = 8'd2;

    typedef enum logic [1:0] {
        REG_SW,
        REG_BTN,
        REG_MASK,
        REG_NONE
    } reg_sel_e;

    // Offset arithmetic wraps, so any address below the base lands outside the window.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] offset;
        offset = addr - base;
        unique case (offset)
            SW_OFFSET:   return REG_SW;
            BTN_OFFSET:  return REG_BTN;
            MASK_OFFSET: return REG_MASK;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/GenericCounter.sv
// Free-running modulo counter; trig_o pulses for one cycle at COUNTER_MAX.
module GenericCounter #(
    parameter int COUNTER_WIDTH = 4,
    parameter int COUNTER_MAX   = 9
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    output logic trig_o
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);

    logic [COUNTER_WIDTH-1:0] count_q;

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= (count_q == MAX_VAL) ? '0 : count_q + COUNTER_WIDTH'(1);
        end
    end

    assign trig_o = enable_i && (count_q == MAX_VAL);

endmodule

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus tick-sampled debounce counter for one raw input.
module input_debouncer
    import switch_button_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam logic [DEB_CNT_W-1:0] LAST_CNT = DEB_CNT_W'(STABLE_SAMPLES - 1);

    logic [1:0]           sync_q;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;

    // NOTE: every signal written here gets a default first, otherwise untaken branches infer latches.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
            if (sync_q[1] != level_q) begin
                if (cnt_q == LAST_CNT) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/switch_button_reader.sv
// Bus-mapped reader for debounced switches/buttons with sticky press flags and a maskable interrupt.
module switch_button_reader
    import switch_button_pkg::*;
#(
    parameter logic [7:0] BaseAddr       = 8'hE0,
    parameter int         TICK_MAX       = 49999,
    parameter int         STABLE_SAMPLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BUTTONS,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int NUM_INPUTS = NUM_SWITCHES + NUM_BUTTONS;
    localparam int TICK_W     = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    logic                    tick;
    logic [NUM_INPUTS-1:0]   raw_in, levels;
    logic [NUM_SWITCHES-1:0] sw_lvl;
    logic [NUM_BUTTONS-1:0]  btn_lvl, btn_prev_q, press;
    logic [NUM_BUTTONS-1:0]  flags_q, flags_d, mask_q;
    logic [7:0]              rd_data_q, rd_data_d;
    logic                    drive_q, raise_q, raise_d;
    logic                    rd_en, rd_clear, wr_mask;
    reg_sel_e                reg_sel;

    GenericCounter #(
        .COUNTER_WIDTH(TICK_W),
        .COUNTER_MAX  (TICK_MAX)
    ) u_prescaler (
        .clk_i   (CLK),
        .rst_n_i (RESET),
        .enable_i(1'b1),
        .trig_o  (tick)
    );

    assign raw_in = {BUTTONS, SWITCHES};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
        input_debouncer #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_deb (
            .clk_i  (CLK),
            .rst_n_i(RESET),
            .tick   (tick),
            .raw    (raw_in[i]),
            .level  (levels[i])
        );
    end

    assign sw_lvl  = levels[NUM_SWITCHES-1:0];
    assign btn_lvl = levels[NUM_INPUTS-1:NUM_SWITCHES];
    assign press   = btn_lvl & ~btn_prev_q;

    assign reg_sel  = decode_addr(BUS_ADDR, BaseAddr);
    assign rd_en    = !BUS_WE && (reg_sel != REG_NONE);
    assign rd_clear = rd_en && (reg_sel == REG_BTN);
    assign wr_mask  = BUS_WE && (reg_sel == REG_MASK);

    // A press arriving on the read-clear edge survives because the OR comes last.
    assign flags_d = (flags_q & ~{NUM_BUTTONS{rd_clear}}) | press;

    always_comb begin
        rd_data_d = 8'h00;
        unique case (reg_sel)
            REG_SW:   rd_data_d = sw_lvl;
            REG_BTN:  rd_data_d = {flags_q, btn_lvl};
            REG_MASK: rd_data_d = {4'b0000, mask_q};
            default:  rd_data_d = 8'h00;
        endcase
    end

    always_comb begin
        raise_d = raise_q;
        if (|(press & mask_q)) begin
            raise_d = 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            btn_prev_q <= '0;
            flags_q    <= '0;
            mask_q     <= '0;
            rd_data_q  <= 8'h00;
            drive_q    <= 1'b0;
            raise_q    <= 1'b0;
        end else begin
            btn_prev_q <= btn_lvl;
            flags_q    <= flags_d;
            rd_data_q  <= rd_data_d;
            drive_q    <= rd_en;
            raise_q    <= raise_d;
            if (wr_mask) begin
                mask_q <= BUS_DATA[3:0];
            end
        end
    end

    assign BUS_DATA            = drive_q ? rd_data_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
